// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and width helpers for the push-button
//                conditioning logic (debounce FSM states, counter sizing).
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

  // Debounce FSM states; the encoding is fixed so it can be observed in
  // board-level debug probes.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  // Larger of two integers, for sizing a counter shared by two limits.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for asynchronous inputs, with an
//                asynchronous active-high reset clearing both stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // Two back-to-back flops give a metastable first stage a full cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : button_pulse_gen
//  Description : Synchronises and debounces a raw push-button, producing a
//                one-cycle enable pulse per confirmed press (plus optional
//                auto-repeat while held) and the registered debounced level.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  import btn_pkg::*;

  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int RCNT_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [CNT_W-1:0]  c_db_last     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_cnt_one     = CNT_W'(1);
  localparam logic [RCNT_W-1:0] c_delay_last  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] c_period_last = RCNT_W'(REPEAT_PERIOD - 1);
  localparam logic [RCNT_W-1:0] c_rcnt_one    = RCNT_W'(1);

  logic              w_btn_sync;
  btn_state_t        r_state;
  btn_state_t        w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [RCNT_W-1:0] r_rcnt;
  logic              r_rep_phase;   // 0: waiting out the first delay, 1: periodic repeats
  logic              r_pulse;
  logic              r_level;

  logic w_db_done;
  logic w_rep_hit;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_rcnt_clr;
  logic w_rcnt_wrap;
  logic w_rcnt_inc;
  logic w_pulse_set;
  logic w_level_set;
  logic w_level_clr;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (w_btn_sync)
  );

  assign w_db_done = (r_cnt == c_db_last);
  assign w_rep_hit = r_rep_phase ? (r_rcnt == c_period_last) : (r_rcnt == c_delay_last);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RELEASED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: any contrary sample in a check state aborts it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RELEASED: begin
        if (w_btn_sync) w_state_next = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!w_btn_sync)    w_state_next = RELEASED;
        else if (w_db_done) w_state_next = PRESSED;
      end
      PRESSED: begin
        if (!w_btn_sync) w_state_next = RELEASE_CHK;
      end
      RELEASE_CHK: begin
        if (w_btn_sync)     w_state_next = PRESSED;
        else if (w_db_done) w_state_next = RELEASED;
      end
      default: w_state_next = RELEASED;
    endcase
  end

  // Output/control decode: counter commands and pulse/level requests.
  always_comb begin
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_rcnt_clr  = 1'b0;
    w_rcnt_wrap = 1'b0;
    w_rcnt_inc  = 1'b0;
    w_pulse_set = 1'b0;
    w_level_set = 1'b0;
    w_level_clr = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_btn_sync) w_cnt_clr = 1'b1;
      end
      PRESS_CHK: begin
        if (w_btn_sync) begin
          if (w_db_done) begin
            w_pulse_set = 1'b1;
            w_level_set = 1'b1;
            w_rcnt_clr  = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!w_btn_sync) begin
          w_cnt_clr = 1'b1;
        end else if (REPEAT_EN) begin
          if (w_rep_hit) begin
            w_pulse_set = 1'b1;
            w_rcnt_wrap = 1'b1;
          end else begin
            w_rcnt_inc = 1'b1;
          end
        end
      end
      RELEASE_CHK: begin
        if (!w_btn_sync) begin
          if (w_db_done) w_level_clr = 1'b1;
          else           w_cnt_inc   = 1'b1;
        end
      end
      default: begin
        w_cnt_clr = 1'b0;
      end
    endcase
  end

  // Debounce stability counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // Repeat counter: restarts on every repeat so it never exceeds its limits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rcnt      <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rcnt_clr) begin
      r_rcnt      <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rcnt_wrap) begin
      r_rcnt      <= '0;
      r_rep_phase <= 1'b1;
    end else if (w_rcnt_inc) begin
      r_rcnt <= r_rcnt + c_rcnt_one;
    end
  end

  // Registered outputs; a pulse is suppressed if the previous cycle already pulsed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_pulse <= w_pulse_set & ~r_pulse;
      if (w_level_set)      r_level <= 1'b1;
      else if (w_level_clr) r_level <= 1'b0;
    end
  end

  assign pulse = r_pulse;
  assign level = r_level;

endmodule : button_pulse_gen
`default_nettype wire

// File: tb/tb_button_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_pulse_gen
//  Description : Self-checking bench for button_pulse_gen. Two instances
//                (auto-repeat off / on) share the button and reset. A
//                run-length model of the debounce rules is compared every
//                cycle, and pulse/level edge times are pinned to literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic pulse_nr, level_nr;
  logic pulse_r,  level_r;

  int n_pass  = 0;
  int n_total = 0;
  int edge_cnt = 0;
  int base = 0;
  bit cmp_en = 1'b0;

  int q_nr[$];
  int q_r[$];
  int lvl_rise[$];
  int lvl_fall[$];
  int exp_q[$];
  logic lvl_prev = 1'b0;

  // Model state
  bit m_s1, m_s2, m_level, m_pnr, m_pr;
  int m_run, m_held;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (DB), .REPEAT_EN (1'b0), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP)
  ) dut_nr (
    .clk (clk), .reset (reset), .btn_in (btn_in), .pulse (pulse_nr), .level (level_nr)
  );

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (DB), .REPEAT_EN (1'b1), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP)
  ) dut_r (
    .clk (clk), .reset (reset), .btn_in (btn_in), .pulse (pulse_r), .level (level_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_q(input string name, input int got[$], input int exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s_edge%0d", name, i), got[i], exp[i]);
  endtask

  // Model: the debounced level flips once DB+1 consecutive synchronised
  // samples disagree with it; repeats count stable-held samples since the press.
  always @(posedge clk or posedge reset) begin : model
    bit s, lvl, pn, pr;
    int run, held;
    if (reset) begin
      m_s1 <= 0; m_s2 <= 0; m_level <= 0; m_pnr <= 0; m_pr <= 0;
      m_run <= 0; m_held <= 0;
    end else begin
      s = m_s2; lvl = m_level; run = m_run; held = m_held; pn = 0; pr = 0;
      if (s == lvl) begin
        if (lvl && run == 0) begin
          held++;
          if (held == RD || (held > RD && (held - RD) % RP == 0)) pr = 1;
        end
        run = 0;
      end else begin
        run++;
        if (run == DB + 1) begin
          lvl = !lvl;
          run = 0;
          if (lvl) begin pn = 1; pr = 1; held = 0; end
        end
      end
      m_s1 <= btn_in; m_s2 <= m_s1; m_level <= lvl;
      m_run <= run; m_held <= held; m_pnr <= pn; m_pr <= pr;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("pulse_norep", int'(pulse_nr), int'(m_pnr));
      chk("level_norep", int'(level_nr), int'(m_level));
      chk("pulse_rep",   int'(pulse_r),  int'(m_pr));
      chk("level_rep",   int'(level_r),  int'(m_level));
    end
  end

  // Edge logger, relative to the scenario's first sampling edge.
  always @(negedge clk) begin
    if (pulse_nr) q_nr.push_back(edge_cnt - base);
    if (pulse_r)  q_r.push_back(edge_cnt - base);
    if (level_nr && !lvl_prev) lvl_rise.push_back(edge_cnt - base);
    if (!level_nr && lvl_prev) lvl_fall.push_back(edge_cnt - base);
    lvl_prev = level_nr;
  end

  task automatic clear_logs();
    q_nr.delete(); q_r.delete(); lvl_rise.delete(); lvl_fall.delete();
  endtask

  // Called at a negedge: the next posedge becomes edge 0.
  task automatic begin_scn();
    @(negedge clk);
    #1;
    clear_logs();
    base = edge_cnt + 1;
  endtask

  task automatic drive(input bit v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pulse_norep", int'(pulse_nr), 0);
    chk("reset_level_norep", int'(level_nr), 0);
    chk("reset_pulse_rep",   int'(pulse_r),  0);
    chk("reset_level_rep",   int'(level_r),  0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press, held 30 cycles
    begin_scn(); drive(1, 30); drive(0, 40);
    exp_q = {6};      chk_q("clean_pulse_norep", q_nr, exp_q);
    exp_q = {6, 26};  chk_q("clean_pulse_rep", q_r, exp_q);
    exp_q = {6};      chk_q("clean_level_rise", lvl_rise, exp_q);
    exp_q = {36};     chk_q("clean_level_fall", lvl_fall, exp_q);

    // Bounce: 1,0,1,0,1,0 then stable 1 from edge 6
    begin_scn();
    for (int i = 0; i < 6; i++) drive((i % 2) == 0, 1);
    drive(1, 16); drive(0, 40);
    exp_q = {12};     chk_q("bounce_pulse_norep", q_nr, exp_q);
    exp_q = {12};     chk_q("bounce_pulse_rep", q_r, exp_q);

    // Short glitch: 3 cycles high
    begin_scn(); drive(1, 3); drive(0, 30);
    chk("glitch_pulses", q_nr.size() + q_r.size(), 0);
    chk("glitch_level_rise", lvl_rise.size(), 0);

    // Auto-repeat: held 60 cycles
    begin_scn(); drive(1, 60); drive(0, 50);
    exp_q = {6, 26, 34, 42, 50, 58}; chk_q("repeat_pulse_rep", q_r, exp_q);
    exp_q = {6};                     chk_q("repeat_pulse_norep", q_nr, exp_q);

    // Held 100 cycles
    begin_scn(); drive(1, 100); drive(0, 50);
    exp_q = {6};      chk_q("hold100_pulse_norep", q_nr, exp_q);
    chk("hold100_rep_count", q_r.size(), 11);

    // Reset while pressed, button kept held through and after reset
    begin_scn(); drive(1, 10);
    chk("pre_reset_level_norep", int'(level_nr), 1);
    chk("pre_reset_level_rep",   int'(level_r),  1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_level_norep", int'(level_nr), 0);
    chk("async_reset_level_rep",   int'(level_r),  0);
    chk("async_reset_pulse_norep", int'(pulse_nr), 0);
    chk("async_reset_pulse_rep",   int'(pulse_r),  0);
    repeat (3) @(negedge clk);
    #1;
    clear_logs();
    base  = edge_cnt + 1;
    reset = 1'b0;
    drive(1, 20); drive(0, 30);
    exp_q = {6};      chk_q("post_reset_pulse_norep", q_nr, exp_q);
    exp_q = {6};      chk_q("post_reset_pulse_rep", q_r, exp_q);
    exp_q = {6};      chk_q("post_reset_level_rise", lvl_rise, exp_q);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_button_pulse_gen
`default_nettype wire

// File: doc/button_pulse_gen.md
# button_pulse_gen

Conditions a raw mechanical push-button into a clean single-clock enable pulse that drives the `T` input of the downstream 3-bit T-flip-flop counter, so each press advances the count by exactly one. The block synchronises the asynchronous input, debounces both edges with a stability counter and emits a one-cycle `pulse` per confirmed press. An optional auto-repeat re-emits pulses while the button is held. It also provides the debounced `level`.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronised cycles required to confirm a press or release (20 ms at 50 MHz). Must be ≥ 1.
- `REPEAT_EN`, default 0: 1 enables auto-repeat while held.
- `REPEAT_DELAY`, default 25_000_000: cycles in PRESSED before the first repeat pulse. Must be ≥ 1.
- `REPEAT_PERIOD`, default 10_000_000: cycles between later repeat pulses. Must be ≥ 1.
- `clk` in 1: single clock. All flops are rising-edge.
- `reset` in 1: asynchronous, active-high. Clears every flop immediately.
- `btn_in` in 1: raw button, active-high, asynchronous to `clk`.
- `pulse` out 1: registered one-cycle enable per confirmed press or repeat. Connects to counter `T`.
- `level` out 1: registered debounced button state.

## Operation
- Synchroniser: two flops, `btn_in` → s1 → `btn_sync`. Both reset to 0.
- FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Reset state is RELEASED.
- RELEASED:
  - `btn_sync`=1 → PRESS_CHK, cnt←0.
- PRESS_CHK:
  - `btn_sync`=0 → RELEASED. No pulse.
  - else if cnt==DEBOUNCE_CYCLES-1 → PRESSED, `pulse`←1, `level`←1, rcnt←0.
  - else cnt←cnt+1.
- PRESSED:
  - `btn_sync`=0 → RELEASE_CHK, cnt←0. rcnt frozen.
  - else, if REPEAT_EN, rcnt←rcnt+1 each cycle:
    - first repeat: rcnt==REPEAT_DELAY-1 → `pulse`←1.
    - later repeats: every REPEAT_PERIOD cycles after that → `pulse`←1.
    - rcnt saturates/wraps only within the repeat phase, never overflows its width.
- RELEASE_CHK:
  - `btn_sync`=1 → PRESSED. No pulse. rcnt resumes from its held value.
  - else if cnt==DEBOUNCE_CYCLES-1 → RELEASED, `level`←0.
  - else cnt←cnt+1.
- `pulse` defaults to 0 every cycle. It is never high for two consecutive cycles.
- Counter widths:
  - cnt: clog2(DEBOUNCE_CYCLES).
  - rcnt: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
  - Minimum width 1 for both.
- Reset values: `pulse`=0, `level`=0, cnt=0, rcnt=0, state=RELEASED.
- Reset mid-operation: outputs drop asynchronously. If the button is still held after release of `reset`, it is handled as a new press with full debounce and one pulse.

## Timing
- Edge 0 is the first edge sampling `btn_in`=1. With the input stable thereafter, `pulse` and `level` rise at edge DEBOUNCE_CYCLES+2. `pulse` falls at edge DEBOUNCE_CYCLES+3.
- Release latency is the same: `level` falls DEBOUNCE_CYCLES+2 edges after the first edge sampling 0.
- Any contrary sample during a CHK state aborts it. The full count restarts on the next qualifying transition.
- Repeat pulses (REPEAT_EN=1), counted from entry to PRESSED at edge P:
  - first repeat at edge P+REPEAT_DELAY.
  - then at P+REPEAT_DELAY+k·REPEAT_PERIOD.
- No combinational path from input to output.

## Structure
- Package `btn_pkg`:
  - FSM state typedef (2-bit encoding: RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3).
  - Width helper constant function.
- Sub-module `sync_2ff`: a two-flop synchroniser with asynchronous reset, reusable for other board inputs.
- The remainder is one FSM plus two counters in `button_pulse_gen`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Clean press: `btn_in`=1 from edge 0, held 30 cycles, then 0.
  - `pulse` high only after edge 6.
  - `level` 1 from edge 6, 0 at edge 6 after release.
- Bounce: `btn_in` toggles each cycle for 6 cycles, then stable 1.
  - Exactly one `pulse`, 6 edges after the last rising sample.
- Short glitch: 3-cycle high then 0 → no `pulse`, `level` stays 0.
- Auto-repeat: REPEAT_EN=1, button held 60 cycles from edge 0.
  - Pulses at edges 6, 26, 34, 42, 50, 58.
  - None after release.
- No repeat: REPEAT_EN=0, button held 100 cycles → exactly one pulse.
- Reset mid-press: assert `reset` while `level`=1 → `pulse`/`level` 0 immediately.
  - Deassert with button held → one pulse 6 edges after the first post-reset sample.
